// File: rtl/rv64g_l2_pkg.sv
// rtl/rv64g_l2_pkg.sv - shared L2 geometry constants and victim sequencer state encoding
package rv64g_l2_pkg;

    localparam int NUM_WAYS = 16;
    localparam int NUM_SETS = 256;
    localparam int SET_W    = 8;
    localparam int WAY_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TAGRD = 3'd1,
        ST_SEL   = 3'd2,
        ST_WB    = 3'd3,
        ST_ALLOC = 3'd4,
        ST_TOUCH = 3'd5
    } victim_state_e;

    // A victim needs a writeback only when it holds live modified data;
    // a stale dirty bit on an invalid way is ignored.
    function automatic logic victim_needs_wb(input logic [NUM_WAYS-1:0] valid,
                                             input logic [NUM_WAYS-1:0] dirty,
                                             input logic [WAY_W-1:0]    way);
        return valid[way] & dirty[way];
    endfunction

endpackage

// File: rtl/rv64g_l2_victim_ctrl.sv
// rtl/rv64g_l2_victim_ctrl.sv - per-miss victim selection, writeback and allocation sequencer
//
// Purpose: accepts one L2 miss at a time, reads the set's valid/dirty masks,
// takes the victim way from the external PLRU unit, issues a writeback when the
// victim is valid and dirty, grants the way to the refill path and finally marks
// it MRU. Also shares the PLRU's single set/access port with hit-path touches.
//
// Ports:
//   clk_i, rst_ni                       clock, async active-low reset
//   miss_valid_i/miss_ready_o/miss_set_i  miss allocation request
//   hit_valid_i/hit_ready_o/hit_set_i/hit_way_i  hit-path PLRU touch
//   tag_rd_o/tag_set_o                  tag/state read; masks return next cycle
//   tag_valid_i/tag_dirty_i             valid and dirty masks of the read set
//   plru_set_o/plru_access_o/plru_used_way_o/plru_valid_o  PLRU port
//   plru_victim_i                       PLRU combinational victim for plru_set_o
//   wb_valid_o/wb_ready_i/wb_set_o/wb_way_o         writeback request
//   alloc_valid_o/alloc_ready_i/alloc_set_o/alloc_way_o  refill grant
module rv64g_l2_victim_ctrl
    import rv64g_l2_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                miss_valid_i,
    output logic                miss_ready_o,
    input  logic [SET_W-1:0]    miss_set_i,
    input  logic                hit_valid_i,
    output logic                hit_ready_o,
    input  logic [SET_W-1:0]    hit_set_i,
    input  logic [WAY_W-1:0]    hit_way_i,
    output logic                tag_rd_o,
    output logic [SET_W-1:0]    tag_set_o,
    input  logic [NUM_WAYS-1:0] tag_valid_i,
    input  logic [NUM_WAYS-1:0] tag_dirty_i,
    output logic [SET_W-1:0]    plru_set_o,
    output logic                plru_access_o,
    output logic [WAY_W-1:0]    plru_used_way_o,
    output logic [NUM_WAYS-1:0] plru_valid_o,
    input  logic [WAY_W-1:0]    plru_victim_i,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [SET_W-1:0]    wb_set_o,
    output logic [WAY_W-1:0]    wb_way_o,
    output logic                alloc_valid_o,
    input  logic                alloc_ready_i,
    output logic [SET_W-1:0]    alloc_set_o,
    output logic [WAY_W-1:0]    alloc_way_o
);

    victim_state_e       state_q, state_d;
    logic [SET_W-1:0]    set_q, set_d;
    logic [WAY_W-1:0]    way_q, way_d;
    logic [NUM_WAYS-1:0] vmask_q, vmask_d;
    logic [NUM_WAYS-1:0] dirty_q, dirty_d;
    logic                hit_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            set_q   <= '0;
            way_q   <= '0;
            vmask_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            way_q   <= way_d;
            vmask_q <= vmask_d;
            dirty_q <= dirty_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        set_d           = set_q;
        way_d           = way_q;
        vmask_d         = vmask_q;
        dirty_d         = dirty_q;
        miss_ready_o    = 1'b0;
        hit_ready       = 1'b1;
        tag_rd_o        = 1'b0;
        wb_valid_o      = 1'b0;
        alloc_valid_o   = 1'b0;
        plru_access_o   = 1'b0;
        plru_set_o      = set_q;
        plru_used_way_o = way_q;
        plru_valid_o    = vmask_q;

        unique case (state_q)
            ST_IDLE: begin
                miss_ready_o = 1'b1;
                if (miss_valid_i) begin
                    set_d   = miss_set_i;
                    state_d = ST_TAGRD;
                end
            end
            ST_TAGRD: begin
                tag_rd_o = 1'b1;
                state_d  = ST_SEL;
            end
            ST_SEL: begin
                // The PLRU port is ours this cycle: it sees the freshly read
                // valid mask so it can pick an invalid way first.
                hit_ready    = 1'b0;
                plru_valid_o = tag_valid_i;
                vmask_d      = tag_valid_i;
                dirty_d      = tag_dirty_i;
                way_d        = plru_victim_i;
                state_d      = victim_needs_wb(tag_valid_i, tag_dirty_i, plru_victim_i)
                             ? ST_WB : ST_ALLOC;
            end
            ST_WB: begin
                wb_valid_o = 1'b1;
                if (wb_ready_i) state_d = ST_ALLOC;
            end
            ST_ALLOC: begin
                alloc_valid_o = 1'b1;
                if (alloc_ready_i) state_d = ST_TOUCH;
            end
            ST_TOUCH: begin
                hit_ready       = 1'b0;
                plru_access_o   = 1'b1;
                plru_used_way_o = way_q;
                state_d         = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Hit touches borrow the PLRU port whenever the sequencer does not own it.
        if (hit_ready && hit_valid_i) begin
            plru_access_o   = 1'b1;
            plru_set_o      = hit_set_i;
            plru_used_way_o = hit_way_i;
        end
    end

    assign hit_ready_o = hit_ready;
    assign tag_set_o   = set_q;
    assign wb_set_o    = set_q;
    assign wb_way_o    = way_q;
    assign alloc_set_o = set_q;
    assign alloc_way_o = way_q;

endmodule

// File: tb/tb_rv64g_l2_victim_ctrl.sv
// tb/tb_rv64g_l2_victim_ctrl.sv - self-checking bench for rv64g_l2_victim_ctrl
module tb_rv64g_l2_victim_ctrl;

    logic        clk;
    logic        rst_ni;
    logic        miss_valid_i, miss_ready_o;
    logic [7:0]  miss_set_i;
    logic        hit_valid_i, hit_ready_o;
    logic [7:0]  hit_set_i;
    logic [3:0]  hit_way_i;
    logic        tag_rd_o;
    logic [7:0]  tag_set_o;
    logic [15:0] tag_valid_i, tag_dirty_i;
    logic [7:0]  plru_set_o;
    logic        plru_access_o;
    logic [3:0]  plru_used_way_o;
    logic [15:0] plru_valid_o;
    logic [3:0]  plru_victim_i;
    logic        wb_valid_o, wb_ready_i;
    logic [7:0]  wb_set_o;
    logic [3:0]  wb_way_o;
    logic        alloc_valid_o, alloc_ready_i;
    logic [7:0]  alloc_set_o;
    logic [3:0]  alloc_way_o;

    rv64g_l2_victim_ctrl dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o), .miss_set_i(miss_set_i),
        .hit_valid_i(hit_valid_i), .hit_ready_o(hit_ready_o),
        .hit_set_i(hit_set_i), .hit_way_i(hit_way_i),
        .tag_rd_o(tag_rd_o), .tag_set_o(tag_set_o),
        .tag_valid_i(tag_valid_i), .tag_dirty_i(tag_dirty_i),
        .plru_set_o(plru_set_o), .plru_access_o(plru_access_o),
        .plru_used_way_o(plru_used_way_o), .plru_valid_o(plru_valid_o),
        .plru_victim_i(plru_victim_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_set_o(wb_set_o), .wb_way_o(wb_way_o),
        .alloc_valid_o(alloc_valid_o), .alloc_ready_i(alloc_ready_i),
        .alloc_set_o(alloc_set_o), .alloc_way_o(alloc_way_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- environment: tag array and tree PLRU ----------------
    logic [15:0] vmem [256];
    logic [15:0] dmem [256];
    logic [14:0] tree [256];

    // Lowest invalid way wins; otherwise follow the tree bits (0 = left) to the LRU leaf.
    function automatic logic [3:0] victim_of(input logic [14:0] t, input logic [15:0] v);
        int n;
        logic [3:0] w;
        for (int i = 0; i < 16; i++) if (!v[i]) return 4'(i);
        n = 0;
        w = '0;
        for (int l = 0; l < 4; l++) begin
            w = {w[2:0], t[n]};
            n = 2 * n + 1 + int'(t[n]);
        end
        return w;
    endfunction

    // Point every node on the path to the used way away from it.
    function automatic logic [14:0] touch(input logic [14:0] t, input logic [3:0] w);
        int n;
        logic b;
        n = 0;
        for (int l = 0; l < 4; l++) begin
            b = w[3-l];
            t[n] = ~b;
            n = 2 * n + 1 + int'(b);
        end
        return t;
    endfunction

    always_comb plru_victim_i = victim_of(tree[plru_set_o], plru_valid_o);

    always @(posedge clk)
        if (rst_ni && plru_access_o) tree[plru_set_o] <= touch(tree[plru_set_o], plru_used_way_o);

    initial begin
        for (int i = 0; i < 256; i++) begin
            tree[i] = '0;
            vmem[i] = '0;
            dmem[i] = '0;
        end
    end

    // Masks return one cycle after the read; junk otherwise so stale-use is visible.
    initial begin
        logic       rd;
        logic [7:0] s;
        tag_valid_i = '0;
        tag_dirty_i = '0;
        forever begin
            @(posedge clk);
            rd = tag_rd_o;
            s  = tag_set_o;
            #1;
            if (rd) begin
                tag_valid_i = vmem[s];
                tag_dirty_i = dmem[s];
            end else begin
                tag_valid_i = 16'($urandom);
                tag_dirty_i = 16'($urandom);
            end
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    // A miss is tracked as its age since acceptance plus the work still owed:
    // writeback, allocation grant, MRU touch - done strictly in that order.
    logic        m_busy, m_wb, m_alloc;
    int          m_age;
    logic [7:0]  m_set;
    logic [3:0]  m_way;
    logic [15:0] m_vmask;
    int          hr_low = 0;

    initial begin
        logic e_tagrd, e_sel, e_wb, e_alloc, e_touch, e_hready, e_hacc, e_acc;
        logic [7:0] e_pset;
        logic [3:0] e_pway;
        m_busy = 0; m_wb = 0; m_alloc = 0; m_age = 0;
        m_set = 0; m_way = 0; m_vmask = 0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                m_busy = 0; m_wb = 0; m_alloc = 0; m_age = 0;
                m_set = 0; m_way = 0; m_vmask = 0;
            end else begin
                e_tagrd  = m_busy && m_age == 1;
                e_sel    = m_busy && m_age == 2;
                e_wb     = m_busy && m_age == 3 && m_wb;
                e_alloc  = m_busy && m_age == 3 && !m_wb && m_alloc;
                e_touch  = m_busy && m_age == 3 && !m_wb && !m_alloc;
                e_hready = !(e_sel || e_touch);
                e_hacc   = hit_valid_i && e_hready;
                e_acc    = e_touch || e_hacc;
                e_pset   = (e_hacc) ? hit_set_i : m_set;
                e_pway   = (e_hacc) ? hit_way_i : m_way;
                if (!hit_ready_o) hr_low++;

                chk("miss_ready", 32'(miss_ready_o), 32'(!m_busy));
                chk("hit_ready", 32'(hit_ready_o), 32'(e_hready));
                chk("tag_rd", 32'(tag_rd_o), 32'(e_tagrd));
                if (e_tagrd) chk("tag_set", 32'(tag_set_o), 32'(m_set));
                chk("plru_access", 32'(plru_access_o), 32'(e_acc));
                chk("plru_set", 32'(plru_set_o), 32'(e_pset));
                if (e_acc) chk("plru_used_way", 32'(plru_used_way_o), 32'(e_pway));
                chk("plru_valid", 32'(plru_valid_o), 32'(e_sel ? tag_valid_i : m_vmask));
                chk("wb_valid", 32'(wb_valid_o), 32'(e_wb));
                if (e_wb) begin
                    chk("wb_set", 32'(wb_set_o), 32'(m_set));
                    chk("wb_way", 32'(wb_way_o), 32'(m_way));
                end
                chk("alloc_valid", 32'(alloc_valid_o), 32'(e_alloc));
                if (e_alloc) begin
                    chk("alloc_set", 32'(alloc_set_o), 32'(m_set));
                    chk("alloc_way", 32'(alloc_way_o), 32'(m_way));
                end

                if (!m_busy) begin
                    if (miss_valid_i) begin
                        m_busy = 1; m_age = 1; m_set = miss_set_i;
                    end
                end else if (m_age == 1) begin
                    m_age = 2;
                end else if (m_age == 2) begin
                    m_vmask = tag_valid_i;
                    m_way   = victim_of(tree[m_set], tag_valid_i);
                    m_wb    = tag_valid_i[m_way] && tag_dirty_i[m_way];
                    m_alloc = 1;
                    m_age   = 3;
                end else if (m_wb) begin
                    if (wb_ready_i) m_wb = 0;
                end else if (m_alloc) begin
                    if (alloc_ready_i) m_alloc = 0;
                end else begin
                    m_busy = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic rand_on   = 0;
    logic hit_storm = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_on) begin
                miss_valid_i  = ($urandom_range(0, 9) < 3);
                miss_set_i    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
                hit_valid_i   = ($urandom_range(0, 1) == 1);
                hit_set_i     = ($urandom_range(0, 1) == 1) ? miss_set_i : 8'($urandom);
                hit_way_i     = 4'($urandom);
                wb_ready_i    = ($urandom_range(0, 1) == 1);
                alloc_ready_i = ($urandom_range(0, 2) != 0);
            end else if (hit_storm) begin
                hit_valid_i = 1'b1;
                hit_set_i   = 8'($urandom);
                hit_way_i   = 4'($urandom);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one miss to completion; the writeback is refused for wb_stall cycles.
    task automatic run_miss(input logic [7:0] s, input int wb_stall,
                            output int lat, output int way, output int nwb);
        int cnt;
        miss_valid_i = 1; miss_set_i = s; wb_ready_i = 0; alloc_ready_i = 0;
        cnt = 0;
        while (!miss_ready_o && cnt < 50) begin step(); cnt++; end
        step();
        miss_valid_i = 0;
        lat = 1; nwb = 0; cnt = 0;
        while (!alloc_valid_o && cnt < 50) begin
            if (wb_valid_o) begin
                nwb++;
                chk("wb_set_stable", 32'(wb_set_o), 32'(s));
                if (nwb > wb_stall) wb_ready_i = 1;
            end
            step();
            wb_ready_i = 0;
            lat++; cnt++;
        end
        chk("alloc_timeout", 32'(cnt < 50), 32'd1);
        way = int'(alloc_way_o);
        alloc_ready_i = 1;
        step();
        alloc_ready_i = 0;
        chk("touch_pulse", 32'(plru_access_o), 32'd1);
        chk("touch_way", 32'(plru_used_way_o), 32'(way));
        step();
    endtask

    initial begin
        int lat, way, nwb, h0, cnt;
        rst_ni = 0;
        miss_valid_i = 0; miss_set_i = 0;
        hit_valid_i = 0; hit_set_i = 0; hit_way_i = 0;
        wb_ready_i = 0; alloc_ready_i = 0;
        repeat (3) step();
        chk("rst_miss_ready", 32'(miss_ready_o), 32'd1);
        chk("rst_hit_ready", 32'(hit_ready_o), 32'd1);
        chk("rst_tag_rd", 32'(tag_rd_o), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst_alloc_valid", 32'(alloc_valid_o), 32'd0);
        chk("rst_plru_access", 32'(plru_access_o), 32'd0);
        chk("rst_plru_set", 32'(plru_set_o), 32'd0);
        rst_ni = 1;
        step();

        // Empty set: way 0 in cycle 3, no writeback.
        vmem[8'h12] = 16'h0000; dmem[8'h12] = 16'hFFFF;
        run_miss(8'h12, 0, lat, way, nwb);
        chk("empty_latency", 32'(lat), 32'd3);
        chk("empty_way", 32'(way), 32'd0);
        chk("empty_nowb", 32'(nwb), 32'd0);

        // Full clean set: tree walk gives 0, then 8 after way 0 became MRU.
        vmem[8'h05] = 16'hFFFF; dmem[8'h05] = 16'h0000;
        run_miss(8'h05, 0, lat, way, nwb);
        chk("tree_way_first", 32'(way), 32'd0);
        chk("tree_nowb", 32'(nwb), 32'd0);
        run_miss(8'h05, 0, lat, way, nwb);
        chk("tree_way_second", 32'(way), 32'd8);

        // Full dirty set: writeback held 4 refused cycles, then accepted.
        vmem[8'h40] = 16'hFFFF; dmem[8'h40] = 16'hFFFF;
        run_miss(8'h40, 4, lat, way, nwb);
        chk("wb_cycles", 32'(nwb), 32'd5);
        chk("wb_way", 32'(way), 32'd0);
        chk("wb_latency", 32'(lat), 32'd8);

        // Invalid way 3 with dirty bit set: chosen, but no writeback.
        vmem[8'h33] = 16'hFFF7; dmem[8'h33] = 16'h0008;
        run_miss(8'h33, 0, lat, way, nwb);
        chk("inv_way", 32'(way), 32'd3);
        chk("inv_nowb", 32'(nwb), 32'd0);

        // Continuous hit traffic: refused exactly in the select and touch cycles.
        vmem[8'h77] = 16'hFFFF; dmem[8'h77] = 16'h0000;
        hit_storm = 1;
        step();
        h0 = hr_low;
        run_miss(8'h77, 0, lat, way, nwb);
        chk("hit_block_cycles", 32'(hr_low - h0), 32'd2);
        hit_storm = 0;
        hit_valid_i = 0;
        step();

        // Reset while a writeback is pending.
        vmem[8'h41] = 16'hFFFF; dmem[8'h41] = 16'hFFFF;
        miss_valid_i = 1; miss_set_i = 8'h41;
        step();
        miss_valid_i = 0;
        step();
        step();
        chk("pre_rst_wb", 32'(wb_valid_o), 32'd1);
        #1 rst_ni = 0;
        #1;
        chk("rst_wb_drop", 32'(wb_valid_o), 32'd0);
        chk("rst_miss_ready_mid", 32'(miss_ready_o), 32'd1);
        step();
        rst_ni = 1;
        step();
        chk("post_rst_ready", 32'(miss_ready_o), 32'd1);
        chk("post_rst_nowb", 32'(wb_valid_o), 32'd0);
        chk("post_rst_notag", 32'(tag_rd_o), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 256; i++) begin
            vmem[i] = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
            dmem[i] = 16'($urandom);
        end
        rand_on = 1;
        repeat (4000) step();
        rand_on = 0;
        miss_valid_i = 0; hit_valid_i = 0; wb_ready_i = 1; alloc_ready_i = 1;
        cnt = 0;
        while (!miss_ready_o && cnt < 50) begin step(); cnt++; end
        chk("drain_idle", 32'(miss_ready_o), 32'd1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv64g_l2_victim_ctrl.md
Name: rv64g_l2_victim_ctrl

Overview:
- Per-miss allocation sequencer for the L2 16-way, 256-set array.
- On each accepted miss it reads the set's valid/dirty masks and obtains a victim way from the shared PLRU replacement unit (invalid-first, else tree walk).
- If the victim is valid and dirty, it issues a writeback first, then hands the way to the refill path and marks that way most-recently-used in the PLRU.
- Also arbitrates the PLRU's single set/access port between hit-path touches and its own allocation touch.

Parameters:
- NUM_WAYS, 16, ways per set; PLRU tree fixed at 16.
- SET_W, 8, set index width (256 sets).
- WAY_W, 4, way index width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- miss_valid_i  in  1  miss allocation request
- miss_ready_o  out  1  request accepted when valid&ready
- miss_set_i  in  SET_W  set of missing line
- hit_valid_i  in  1  hit-path PLRU touch request
- hit_ready_o  out  1  touch accepted when valid&ready
- hit_set_i  in  SET_W  set of hit
- hit_way_i  in  WAY_W  way of hit
- tag_rd_o  out  1  tag/state array read strobe
- tag_set_o  out  SET_W  tag read set
- tag_valid_i  in  NUM_WAYS  valid mask, 1 cycle after tag_rd_o
- tag_dirty_i  in  NUM_WAYS  dirty mask, 1 cycle after tag_rd_o
- plru_set_o  out  SET_W  PLRU set index
- plru_access_o  out  1  PLRU update strobe
- plru_used_way_o  out  WAY_W  PLRU used way
- plru_valid_o  out  NUM_WAYS  valid mask to PLRU
- plru_victim_i  in  WAY_W  PLRU combinational victim for plru_set_o
- wb_valid_o  out  1  writeback request
- wb_ready_i  in  1  writeback accepted
- wb_set_o  out  SET_W  writeback set
- wb_way_o  out  WAY_W  writeback way
- alloc_valid_o  out  1  allocation grant to refill path
- alloc_ready_i  in  1  refill path accepted
- alloc_set_o  out  SET_W  allocated set
- alloc_way_o  out  WAY_W  allocated way

Behaviour:
- FSM states: IDLE, TAGRD, SEL, WB, ALLOC, TOUCH. Reset: state IDLE; set_q, way_q, vmask_q, dirty_q all 0; every output 0 except miss_ready_o=1 and hit_ready_o=1.
- IDLE: miss_ready_o=1. On miss handshake, latch set_q=miss_set_i, go to TAGRD.
- TAGRD: tag_rd_o=1, tag_set_o=set_q, one cycle, go to SEL.
- SEL: capture tag_valid_i/tag_dirty_i into vmask_q/dirty_q.
  - Drive plru_set_o=set_q and plru_valid_o=tag_valid_i (same cycle).
  - Latch way_q=plru_victim_i and the victim's valid&dirty bit.
  - If the victim is valid and dirty, go to WB; else go to ALLOC.
- WB: wb_valid_o=1 with set_q/way_q, held stable until wb_ready_i, then go to ALLOC.
- ALLOC: alloc_valid_o=1 with set_q/way_q, held stable until alloc_ready_i, then go to TOUCH.
- TOUCH: plru_access_o=1, plru_set_o=set_q, plru_used_way_o=way_q, one cycle, go to IDLE.
- Best-case latency from miss acceptance to alloc_valid_o: 3 cycles (no writeback, no stall).
- PLRU port arbitration:
  - hit_ready_o=0 in SEL and TOUCH; those states own plru_set_o.
  - Otherwise hit_ready_o=1, and an accepted hit drives plru_access_o=1, plru_set_o=hit_set_i, plru_used_way_o=hit_way_i in the same cycle.
  - With no hit, plru_set_o=set_q and plru_valid_o=vmask_q.
- Hit touches during WB/ALLOC are permitted. The victim is already latched, so PLRU changes do not alter way_q.
- Only one miss is outstanding at a time. miss_ready_o=0 outside IDLE.
- Simultaneous miss and hit in IDLE: both are accepted; the hit updates the PLRU that cycle.
- Hit to the same set as an outstanding miss in WB/ALLOC: permitted. TOUCH runs last, so the allocated way ends up MRU.
- Reset mid-operation: returns immediately to IDLE; any pending wb/alloc request is dropped and not replayed.
- Invalid victim: no writeback, even if its dirty bit is set (valid gates dirty).

Decomposition:
- Shared package rv64g_l2_pkg: SET_W, WAY_W, NUM_WAYS, NUM_SETS, the state enum encoding (IDLE=0…TOUCH=5).
- No sub-module. The PLRU unit rv64g_l2_plru is instantiated alongside this block at L2 top level, not inside it.

Test Plan:
- Empty set 0x12 (valid=0x0000): miss → alloc_way_o=0 in cycle 3, no wb_valid_o; after alloc handshake, a plru_access_o pulse with way 0.
- Set 0x05 all valid, dirty=0x0000, after reset: victim way 0 via tree walk, no writeback; a repeat miss after TOUCH yields way 8.
- Set 0x40 all valid, dirty=0xFFFF: wb_valid_o way 0 held 4 cycles with wb_ready_i=0, then ALLOC. Check wb_set_o=0x40 stable throughout.
- Valid=0xFFF7, dirty=0x0008: victim way 3 (invalid-first), no writeback despite the dirty bit.
- Hit touch asserted every cycle during a miss: hit_ready_o=0 exactly in SEL and TOUCH. Touches in other states produce plru_access_o with hit_way_i.
- rst_ni asserted during WB: wb_valid_o drops in the same cycle, FSM is in IDLE on release, and miss_ready_o=1.
